ad7606_if: RTL and testbench

- Responder side of the AD7606 configuration write interface: accepts the 16-bit config word and active-low write strobe.
- Drives the AD7606 pins: OS, RANGE, STBY, RESET, CONVST, CS, RD.
- Runs periodic conversions and reads back the enabled channels over the 16-bit parallel bus.
- Sits between the config controller and the sample-processing/packing logic.

---
 rtl/ad7606_pkg.sv | 36 +++
 rtl/ad7606_if_if.sv | 33 +++
 rtl/ad7606_sync2.sv | 21 ++
 rtl/ad7606_if.sv | 156 +++++++++++++++
 tb/tb_ad7606_if.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ad7606_pkg.sv
// Shared types for the AD7606 front end: FSM states, config word layout and the active-config record.
package ad7606_pkg;

    localparam int CH_MSB    = 7;
    localparam int CH_LSB    = 5;
    localparam int OS_MSB    = 4;
    localparam int OS_LSB    = 2;
    localparam int STBY_BIT  = 1;
    localparam int RANGE_BIT = 0;

    typedef enum logic [2:0] {
        S_RST,
        S_IDLE,
        S_CONV,
        S_BUSY,
        S_RD_LO,
        S_RD_HI
    } state_t;

    typedef struct packed {
        logic [2:0] ch_last;
        logic [2:0] os;
        logic       stby;
        logic       range_sel;
    } cfg_t;

    function automatic cfg_t cfg_decode(input logic [7:0] w);
        cfg_t c;
        c.ch_last   = w[CH_MSB:CH_LSB];
        c.os        = w[OS_MSB:OS_LSB];
        c.stby      = w[STBY_BIT];
        c.range_sel = w[RANGE_BIT];
        return c;
    endfunction

endpackage

// File: rtl/ad7606_if_if.sv
// Pin/bus bundle between the config controller, the AD7606 and the sample consumer.
// slave = the ad7606_if block itself, master = its environment.
interface ad7606_if_if;
    logic [15:0] cfg_data_i;
    logic        cfg_wr_n_i;
    logic [2:0]  ad_os_o;
    logic        ad_range_o;
    logic        ad_stby_n_o;
    logic        ad_reset_o;
    logic        ad_convst_o;
    logic        ad_cs_n_o;
    logic        ad_rd_n_o;
    logic        ad_busy_i;
    logic        ad_frstdata_i;
    logic [15:0] ad_db_i;
    logic [15:0] sample_o;
    logic [2:0]  sample_ch_o;
    logic        sample_vld_o;
    logic        frame_done_o;
    logic        err_o;

    modport slave (
        input  cfg_data_i, cfg_wr_n_i, ad_busy_i, ad_frstdata_i, ad_db_i,
        output ad_os_o, ad_range_o, ad_stby_n_o, ad_reset_o, ad_convst_o, ad_cs_n_o,
               ad_rd_n_o, sample_o, sample_ch_o, sample_vld_o, frame_done_o, err_o
    );

    modport master (
        output cfg_data_i, cfg_wr_n_i, ad_busy_i, ad_frstdata_i, ad_db_i,
        input  ad_os_o, ad_range_o, ad_stby_n_o, ad_reset_o, ad_convst_o, ad_cs_n_o,
               ad_rd_n_o, sample_o, sample_ch_o, sample_vld_o, frame_done_o, err_o
    );
endinterface

// File: rtl/ad7606_sync2.sv
// Two-flop synchroniser for asynchronous ADC status lines; 2-cycle latency, no backpressure.
module ad7606_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ad7606_if.sv
// AD7606 controller: config capture, periodic CONVST, BUSY wait and per-channel parallel readback.
// Pins are registered from the next state; samples appear one cycle after the last RD low cycle, no backpressure.
module ad7606_if #(
    parameter int CONV_PERIOD  = 909,
    parameter int RESET_CYCLES = 4,
    parameter int CONVST_LOW   = 2,
    parameter int RD_LOW       = 3,
    parameter int RD_HIGH      = 2,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    ad7606_if_if.slave  bus
);
    import ad7606_pkg::*;

    localparam int PW = $clog2(CONV_PERIOD);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_t         state, state_nxt;
    logic [TW-1:0]  tmr;
    logic [PW-1:0]  per_cnt;
    logic           per_hit, per_end;
    logic [2:0]     ch;
    cfg_t           cfg, shadow;
    logic           cfg_pend, cfg_valid, run_seen;
    logic           wr_n_q, wr_fall, apply, capture, busy_to;
    logic           busy_s, frst_s, busy_seen;
    logic           convst_q, cs_n_q, rd_n_q, reset_q;
    logic [15:0]    sample_q;
    logic [2:0]     sample_ch_q;
    logic           vld_q, fd_q, err_q;
    logic           cfg_unused;

    ad7606_sync2 #(.W(1)) u_sync_busy (.clk_i(clk_i), .rst_n_i(rst_n_i), .d(bus.ad_busy_i),     .q(busy_s));
    ad7606_sync2 #(.W(1)) u_sync_frst (.clk_i(clk_i), .rst_n_i(rst_n_i), .d(bus.ad_frstdata_i), .q(frst_s));

    assign cfg_unused = ^bus.cfg_data_i[15:8];
    assign wr_fall    = wr_n_q & ~bus.cfg_wr_n_i;
    assign apply      = (state == S_IDLE) && cfg_pend;
    assign per_end    = (per_cnt == PW'(CONV_PERIOD - 1));
    assign capture    = (state == S_RD_LO) && (tmr == TW'(RD_LOW - 1));
    assign busy_to    = (state == S_BUSY) && (tmr == TW'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_RST;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // The reset timer only runs once the pin is actually high, so power-up and
            // standby-exit pulses have the same width.
            S_RST:   if (reset_q && tmr == TW'(RESET_CYCLES - 1)) state_nxt = S_IDLE;
            S_IDLE: begin
                if (apply) begin
                    if (shadow.stby && !cfg.stby && run_seen) state_nxt = S_RST;
                end else if (cfg_valid && cfg.stby && (per_hit || per_end)) begin
                    state_nxt = S_CONV;
                end
            end
            S_CONV:  if (tmr == TW'(CONVST_LOW - 1)) state_nxt = S_BUSY;
            S_BUSY: begin
                if (busy_to)                   state_nxt = S_RST;
                else if (busy_seen && !busy_s) state_nxt = S_RD_LO;
            end
            S_RD_LO: if (capture) state_nxt = S_RD_HI;
            S_RD_HI: if (tmr == TW'(RD_HIGH - 1)) state_nxt = (ch == cfg.ch_last) ? S_IDLE : S_RD_LO;
            default: state_nxt = S_RST;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmr         <= '0;
            per_cnt     <= '0;
            per_hit     <= 1'b0;
            ch          <= '0;
            cfg         <= '0;
            shadow      <= '0;
            cfg_pend    <= 1'b0;
            cfg_valid   <= 1'b0;
            run_seen    <= 1'b0;
            wr_n_q      <= 1'b1;
            busy_seen   <= 1'b0;
            convst_q    <= 1'b1;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            reset_q     <= 1'b0;
            sample_q    <= '0;
            sample_ch_q <= '0;
            vld_q       <= 1'b0;
            fd_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (state_nxt != state)          tmr <= '0;
            else if (state != S_RST || reset_q) tmr <= tmr + TW'(1);

            // Period restarts on the CONVST falling edge; per_hit remembers a wrap during a frame.
            if (state_nxt == S_CONV && state != S_CONV) begin
                per_cnt <= '0;
                per_hit <= 1'b0;
            end else begin
                per_cnt <= per_end ? '0 : per_cnt + PW'(1);
                if (per_end) per_hit <= 1'b1;
            end

            wr_n_q <= bus.cfg_wr_n_i;
            if (wr_fall) begin
                shadow   <= cfg_decode(bus.cfg_data_i[7:0]);
                cfg_pend <= 1'b1;
            end else if (apply) begin
                cfg_pend <= 1'b0;
            end
            if (apply) begin
                cfg       <= shadow;
                cfg_valid <= 1'b1;
            end
            if (cfg_valid && cfg.stby) run_seen <= 1'b1;

            if (state != S_BUSY) busy_seen <= 1'b0;
            else if (busy_s)     busy_seen <= 1'b1;

            if (state == S_BUSY)                              ch <= '0;
            else if (state == S_RD_HI && state_nxt == S_RD_LO) ch <= ch + 3'd1;

            if (capture) begin
                sample_q    <= bus.ad_db_i;
                sample_ch_q <= ch;
                if (frst_s != (ch == 3'd0)) err_q <= 1'b1;
            end
            if (busy_to) err_q <= 1'b1;
            vld_q <= capture;
            fd_q  <= (state == S_RD_HI) && (state_nxt == S_IDLE);

            convst_q <= (state_nxt != S_CONV);
            cs_n_q   <= !(state_nxt == S_RD_LO || state_nxt == S_RD_HI);
            rd_n_q   <= (state_nxt != S_RD_LO);
            reset_q  <= (state_nxt == S_RST);
        end
    end

    assign bus.ad_os_o      = cfg.os;
    assign bus.ad_range_o   = cfg.range_sel;
    assign bus.ad_stby_n_o  = cfg_valid & cfg.stby;
    assign bus.ad_reset_o   = reset_q;
    assign bus.ad_convst_o  = convst_q;
    assign bus.ad_cs_n_o    = cs_n_q;
    assign bus.ad_rd_n_o    = rd_n_q;
    assign bus.sample_o     = sample_q;
    assign bus.sample_ch_o  = sample_ch_q;
    assign bus.sample_vld_o = vld_q;
    assign bus.frame_done_o = fd_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_ad7606_if.sv
// Directed bench for ad7606_if with a behavioural AD7606 (BUSY pulse, channel-indexed data, FRSTDATA).
module tb_ad7606_if;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    ad7606_if_if bus();

    ad7606_if dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model controls
    bit busy_stuck = 1'b0;
    bit frst_bad   = 1'b0;

    // Monitor results
    int n_vld = 0, n_fd = 0, n_rise = 0, rise_last = 0, rise_prev = 0;
    int samp_bad = 0, n_rst_runs = 0, last_rst_w = 0;
    logic [2:0] last_ch = 3'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] d);
        bus.cfg_data_i = d;
        bus.cfg_wr_n_i = 1'b0;
        cycles(2);
        bus.cfg_wr_n_i = 1'b1;
        cycles(1);
    endtask

    task automatic wait_fd(input string tag, input int lim);
        int start;
        int k;
        start = n_fd;
        k = 0;
        while (n_fd == start && k < lim) begin
            @(negedge clk);
            k++;
        end
        cycles(1);
        check(tag, 32'(n_fd != start), 32'd1);
    endtask

    // Behavioural ADC: BUSY high 20 cycles after CONVST rises, data = 0x1000 + channel.
    initial begin
        int  bcnt;
        int  rdc;
        logic cv_p;
        logic rd_p;
        bcnt = 0; rdc = 0; cv_p = 1'b1; rd_p = 1'b1;
        bus.ad_busy_i = 1'b0; bus.ad_frstdata_i = 1'b0; bus.ad_db_i = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.ad_convst_o && !cv_p && !busy_stuck) bcnt = 20;
            if (!bus.ad_convst_o && cv_p) rdc = 0;
            if (bus.ad_rd_n_o && !rd_p) rdc++;
            bus.ad_busy_i = (bcnt != 0);
            if (bcnt != 0) bcnt--;
            bus.ad_db_i = 16'h1000 + 16'(rdc);
            bus.ad_frstdata_i = (rdc == 0) && !frst_bad;
            cv_p = bus.ad_convst_o;
            rd_p = bus.ad_rd_n_o;
        end
    end

    // Passive monitor: counts pulses, checks sample order/content into samp_bad.
    initial begin
        logic [2:0] exp_ch;
        logic cv_p;
        int rst_w;
        exp_ch = 3'd0; cv_p = 1'b1; rst_w = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) exp_ch = 3'd0;
            if (!bus.ad_convst_o && cv_p) exp_ch = 3'd0;
            if (bus.ad_convst_o && !cv_p) begin
                rise_prev = rise_last;
                rise_last = cyc;
                n_rise++;
            end
            if (bus.sample_vld_o) begin
                n_vld++;
                last_ch = bus.sample_ch_o;
                if (bus.sample_ch_o != exp_ch || bus.sample_o != (16'h1000 + 16'(exp_ch))) samp_bad++;
                exp_ch = exp_ch + 3'd1;
            end
            if (bus.frame_done_o) begin
                n_fd++;
                exp_ch = 3'd0;
            end
            if (bus.ad_reset_o) rst_w++;
            else if (rst_w != 0) begin
                last_rst_w = rst_w;
                n_rst_runs++;
                rst_w = 0;
            end
            cv_p = bus.ad_convst_o;
        end
    end

    initial begin
        int base, runs, fd_snap, rise_snap, k, cyc_err;
        bus.cfg_data_i = 16'h0;
        bus.cfg_wr_n_i = 1'b1;
        cycles(3);

        // Reset state
        check("rst_pins", {bus.ad_convst_o, bus.ad_cs_n_o, bus.ad_rd_n_o, bus.ad_reset_o, bus.ad_stby_n_o}, 5'b11100);
        check("rst_data", {bus.ad_os_o, bus.ad_range_o, bus.sample_o, bus.sample_ch_o,
                           bus.sample_vld_o, bus.frame_done_o, bus.err_o}, 32'h0);
        rst_n = 1'b1;
        cycles(10);
        check("por_reset_width", last_rst_w, 4);
        check("por_reset_runs", n_rst_runs, 1);
        check("unconfigured_stby_n", bus.ad_stby_n_o, 1'b0);

        // Test 1: full 8-channel frames
        wr(16'h00EA);
        cycles(3);
        check("cfg_pins_ea", {bus.ad_os_o, bus.ad_range_o, bus.ad_stby_n_o}, {3'b010, 1'b0, 1'b1});
        check("no_convst_before_period", n_rise, 0);
        wait_fd("fd1_seen", 2500);
        check("frame1_vld", n_vld, 8);
        check("frame1_last_ch", last_ch, 3'd7);
        check("frame1_fd", n_fd, 1);
        wait_fd("fd2_seen", 2500);
        check("frame2_vld", n_vld, 16);
        check("convst_rises", n_rise, 2);
        check("convst_period", rise_last - rise_prev, 909);
        check("samples_ok_1", samp_bad, 0);

        // Test 2: config change mid-frame takes effect on the next frame only
        base = n_vld;
        k = 0;
        while (n_vld == base && k < 1500) begin @(negedge clk); k++; end
        wr(16'h0002);
        wait_fd("fd3_seen", 2500);
        check("midframe_frame_vld", n_vld - base, 8);
        base = n_vld;
        wait_fd("fd4_seen", 2500);
        check("single_ch_frame_vld", n_vld - base, 1);
        check("single_ch_last", last_ch, 3'd0);
        check("os_after_0002", bus.ad_os_o, 3'b000);

        // Test 3: standby and exit through reset
        wr(16'h00E8);
        cycles(100);
        check("standby_stby_n", bus.ad_stby_n_o, 1'b0);
        rise_snap = n_rise;
        cycles(2000);
        check("standby_no_convst", n_rise - rise_snap, 0);
        runs = n_rst_runs;
        wr(16'h00EA);
        cycles(20);
        check("stby_exit_reset_runs", n_rst_runs - runs, 1);
        check("stby_exit_reset_width", last_rst_w, 4);
        base = n_vld;
        wait_fd("fd5_seen", 2500);
        check("resume_vld", n_vld - base, 8);

        // Test 4: BUSY never rises -> timeout
        busy_stuck = 1'b1;
        runs = n_rst_runs;
        k = 0;
        while (bus.err_o !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        cyc_err = cyc;
        check("busy_timeout_err", bus.err_o, 1'b1);
        check("busy_timeout_cycles", cyc_err - rise_last, 1024);
        busy_stuck = 1'b0;
        cycles(10);
        check("timeout_reset_runs", n_rst_runs - runs, 1);
        check("timeout_reset_width", last_rst_w, 4);
        wait_fd("fd6_seen", 2500);
        check("err_sticky", bus.err_o, 1'b1);
        check("samples_ok_2", samp_bad, 0);

        // Test 5: FRSTDATA wrong at ch 0
        rst_n = 1'b0;
        cycles(2);
        check("err_cleared_by_reset", bus.err_o, 1'b0);
        rst_n = 1'b1;
        cycles(10);
        frst_bad = 1'b1;
        wr(16'h00EA);
        base = n_vld;
        wait_fd("fd7_seen", 2500);
        check("frst_err", bus.err_o, 1'b1);
        check("frst_all_vld", n_vld - base, 8);
        check("samples_ok_3", samp_bad, 0);
        frst_bad = 1'b0;

        // Test 6: held-low strobe captures once; reset during ch 3
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(10);
        bus.cfg_data_i = 16'h00EA;
        bus.cfg_wr_n_i = 1'b0;
        cycles(50);
        bus.cfg_data_i = 16'h0002;
        cycles(50);
        bus.cfg_wr_n_i = 1'b1;
        cycles(5);
        check("held_low_single_capture_os", bus.ad_os_o, 3'b010);
        wait_fd("fd8_seen", 2500);
        base = n_vld;
        k = 0;
        while (n_vld < base + 3 && k < 1500) begin @(negedge clk); k++; end
        k = 0;
        while (bus.ad_rd_n_o !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("reached_ch3_read", {bus.ad_rd_n_o, bus.ad_cs_n_o}, 2'b00);
        fd_snap = n_fd;
        rst_n = 1'b0;
        #1;
        check("async_rst_strobes", {bus.ad_cs_n_o, bus.ad_rd_n_o, bus.ad_convst_o}, 3'b111);
        cycles(3);
        rst_n = 1'b1;
        cycles(100);
        check("no_fd_after_abort", n_fd - fd_snap, 0);
        check("no_vld_after_abort", n_vld - base, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
